// File: rtl/alu_muldiv_unit.sv
// ---------------------------------------------------------------------------
// alu_muldiv_unit
// Execute unit for RV32I ALU ops plus RV32M mul/div/rem behind a
// valid/ready handshake. ALU ops and division corner cases finish in one
// cycle. mul/div run an iterative radix-2 datapath: WIDTH iteration cycles
// plus one sign-fix cycle.
//
// Build option:
//   ALU_MULDIV_EN  defined   -> ops 8-15 executed, out_illegal always 0
//                  undefined -> iterative datapath not built; ops 8-15
//                               complete in one cycle with out_f=0,
//                               out_illegal=1
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 sync abort: drops in-flight op and held result
//   in_valid/in_ready     request handshake
//   in_op, in_a, in_b     opcode (0..15) and operands (a=rs1, b=rs2)
//   in_tag                opaque tag returned with the result
//   out_valid/out_ready   result handshake
//   out_f, out_tag        result and its tag
//   out_illegal           op not supported in this build
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no work; ready for a request
// MUL    | shift-add iterations, then sign fix when the counter hits 0
// DIV    | restoring-division iterations, then sign fix at counter 0
// DONE   | result held on out_*; leaves on out_ready (may reload)
// ---------------------------------------------------------------------------
module alu_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   localparam int SH_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d, start_state;
   logic             accept;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] quick_res;
   logic             quick_ill;
   logic             res_en;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ill_q, ill_d;
   logic [TAG_W-1:0] tag_q;

   assign accept = in_valid & in_ready;
   assign shamt  = in_b[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      case (in_op[2:0])
         3'd0: alu_res = in_a + in_b;
         3'd1: alu_res = in_a << shamt;
         3'd2: alu_res = $signed(in_a) >>> shamt;
         3'd3: alu_res = in_a - in_b;
         3'd4: alu_res = in_a ^ in_b;
         3'd5: alu_res = in_a >> shamt;
         3'd6: alu_res = in_a | in_b;
         default: alu_res = in_a & in_b;
      endcase
   end

`ifdef ALU_MULDIV_EN
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic               sgn_a, sgn_b, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               b_zero, div_ovf;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   opnd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_quo_q, neg_rem_q;
   logic [1:0]         op_lo_q;
   logic [WIDTH:0]     add_sum, div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_borrow;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, fin_res;
   logic               iter_busy;

   // Signedness per op: mulh s*s, mulhsu s*u, mul/mulhu u*u, div/rem signed.
   always_comb begin
      if (in_op[2]) begin
         sgn_a = ~in_op[0];
         sgn_b = ~in_op[0];
      end else begin
         sgn_a = (in_op[1:0] == 2'b01) | (in_op[1:0] == 2'b10);
         sgn_b = (in_op[1:0] == 2'b01);
      end
   end

   // Both datapaths work on magnitudes; the sign is restored in the last cycle.
   assign a_neg   = sgn_a & in_a[WIDTH-1];
   assign b_neg   = sgn_b & in_b[WIDTH-1];
   assign a_mag   = a_neg ? -in_a : in_a;
   assign b_mag   = b_neg ? -in_b : in_b;
   assign b_zero  = (in_b == '0);
   assign div_ovf = ~in_op[0] & (in_a == MIN_VAL) & (in_b == '1);

   assign iter_busy = (state_q == S_MUL) | (state_q == S_DIV);

   // prod_q: MUL = {partial product, remaining multiplier bits}
   //         DIV = {partial remainder, dividend bits becoming quotient}
   always_comb begin
      add_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      div_shift  = prod_q[2*WIDTH-1:WIDTH-1];
      div_borrow = div_shift < {1'b0, opnd_q};
      div_diff   = div_shift[WIDTH-1:0] - opnd_q;
      prod_d     = prod_q;
      if (state_q == S_MUL) begin
         prod_d = {add_sum, prod_q[WIDTH-1:1]};
      end else if (state_q == S_DIV) begin
         prod_d = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff),
                   prod_q[WIDTH-2:0], ~div_borrow};
      end
   end

   always_comb begin
      prod_fix = neg_quo_q ? -prod_q : prod_q;
      quo_fix  = neg_quo_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
      if (state_q == S_MUL) begin
         fin_res = (op_lo_q == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
      end else begin
         fin_res = op_lo_q[1] ? rem_fix : quo_fix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q    <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         op_lo_q   <= 2'b00;
      end else if (accept && (start_state == S_MUL || start_state == S_DIV)) begin
         opnd_q    <= in_op[2] ? b_mag : a_mag;
         prod_q    <= {{WIDTH{1'b0}}, (in_op[2] ? a_mag : b_mag)};
         cnt_q     <= CNT_W'(WIDTH);
         neg_quo_q <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
         op_lo_q   <= in_op[1:0];
      end else if (iter_busy && cnt_q != '0) begin
         prod_q <= prod_d;
         cnt_q  <= cnt_q - 1'b1;
      end
   end
`endif

   // Start state and single-cycle results for a request being accepted.
   always_comb begin
      start_state = S_DONE;
      quick_res   = alu_res;
      quick_ill   = 1'b0;
      if (in_op[3]) begin
`ifdef ALU_MULDIV_EN
         if (!in_op[2]) begin
            start_state = S_MUL;
         end else if (b_zero) begin
            quick_res = in_op[1] ? in_a : '1;
         end else if (div_ovf) begin
            quick_res = in_op[1] ? '0 : MIN_VAL;
         end else begin
            start_state = S_DIV;
         end
`else
         quick_res = '0;
         quick_ill = 1'b1;
`endif
      end
   end

   always_comb begin
      res_en = 1'b0;
      res_d  = quick_res;
      ill_d  = quick_ill;
      if (accept && start_state == S_DONE) begin
         res_en = 1'b1;
      end
`ifdef ALU_MULDIV_EN
      else if (!flush && iter_busy && cnt_q == '0) begin
         res_en = 1'b1;
         res_d  = fin_res;
         ill_d  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         ill_q <= 1'b0;
         tag_q <= '0;
      end else begin
         if (accept) tag_q <= in_tag;
         if (res_en) begin
            res_q <= res_d;
            ill_q <= ill_d;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = start_state;
`ifdef ALU_MULDIV_EN
         S_MUL, S_DIV: if (cnt_q == '0) state_d = S_DONE;
`endif
         S_DONE: if (out_ready) state_d = accept ? start_state : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // FSM: outputs
   always_comb begin
      out_valid = (state_q == S_DONE);
      in_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
   end

   assign out_f       = res_q;
   assign out_tag     = tag_q;
   assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = 4'd0;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic [4:0]  in_tag = 5'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_f;
   logic [4:0]  out_tag;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
      .out_tag(out_tag), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: plain integer arithmetic on 64-bit values.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] f, output logic ill, output int lat);
      logic [63:0] p;
      longint      sa, sb;
      int          sh;
      sh  = int'(b[4:0]);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      f   = 32'd0;
      ill = 1'b0;
      lat = 1;
      p   = 64'd0;
      case (op)
         4'd0: f = a + b;
         4'd1: f = a << sh;
         4'd2: f = 32'(sa >>> sh);
         4'd3: f = a - b;
         4'd4: f = a ^ b;
         4'd5: f = a >> sh;
         4'd6: f = a | b;
         4'd7: f = a & b;
         default: begin
`ifdef ALU_MULDIV_EN
            if (op < 4'd12) begin
               lat = 33;
               case (op)
                  4'd8:    p = {32'd0, a} * {32'd0, b};
                  4'd9:    p = 64'(sa * sb);
                  4'd10:   p = 64'(sa * longint'({32'd0, b}));
                  default: p = {32'd0, a} * {32'd0, b};
               endcase
               f = (op == 4'd8) ? p[31:0] : p[63:32];
            end else if (b == 32'd0) begin
               f = (op >= 4'd14) ? a : 32'hFFFF_FFFF;
            end else if ((op == 4'd12 || op == 4'd14) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               f = (op == 4'd12) ? 32'h8000_0000 : 32'd0;
            end else begin
               lat = 33;
               case (op)
                  4'd12:   f = 32'(sa / sb);
                  4'd13:   f = a / b;
                  4'd14:   f = 32'(sa % sb);
                  default: f = a % b;
               endcase
            end
`else
            f   = 32'd0;
            ill = 1'b1;
`endif
         end
      endcase
   endtask

   // Issue one request with out_ready=1 and check result, tag, illegal and latency.
   task automatic run_txn(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_f,
                          input logic exp_ill, input int exp_lat);
      logic [4:0] tag;
      int         lat;
      tag = 5'($urandom);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      end
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      in_tag   = 5'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (out_valid !== 1'b1 && lat < 100);
      n_checks++;
      if (lat !== exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (out_f !== exp_f) begin
         n_fail++;
         $display("FAIL %s out_f: op=%0d a=%h b=%h got %h want %h", name, op, a, b, out_f, exp_f);
      end
      n_checks++;
      if (out_illegal !== exp_ill) begin
         n_fail++;
         $display("FAIL %s out_illegal: got %b want %b", name, out_illegal, exp_ill);
      end
      n_checks++;
      if (out_tag !== tag) begin
         n_fail++;
         $display("FAIL %s out_tag: got %h want %h", name, out_tag, tag);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out_f !== 32'd0) begin n_fail++; $display("FAIL reset out_f: got %h want 0", out_f); end
      n_checks++;
      if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset out_tag: got %h want 0", out_tag); end
      n_checks++;
      if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset out_illegal: got %b want 0", out_illegal); end
   endtask

   task automatic test_directed;
      run_txn("sra_dir", 4'd2, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1);
`ifdef ALU_MULDIV_EN
      run_txn("mulh_dir",  4'd9,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
      run_txn("mul_dir",   4'd8,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33);
      run_txn("div_ovf",   4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
      run_txn("rem_ovf",   4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
      run_txn("divu_by0",  4'd13, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
      run_txn("remu_by0",  4'd15, 32'd7, 32'd0, 32'd7, 1'b0, 1);
      run_txn("div_m7_2",  4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
      run_txn("rem_m7_2",  4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
`else
      run_txn("mul_ill",   4'd8,  32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1, 1);
      run_txn("mulh_ill",  4'd9,  32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1, 1);
      run_txn("div_ill",   4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
      run_txn("remu_ill",  4'd15, 32'd7, 32'd0, 32'd0, 1'b1, 1);
`endif
   endtask

   task automatic test_alu_random;
      logic [3:0]  op;
      logic [31:0] a, b, f;
      logic        ill;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         model(op, a, b, f, ill, lat);
         run_txn("alu_rand", op, a, b, f, ill, lat);
      end
   endtask

   task automatic test_muldiv_random;
      logic [3:0]  op;
      logic [31:0] a, b, f;
      logic        ill;
      int          lat;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(8, 15));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 9));
            4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         model(op, a, b, f, ill, lat);
         run_txn("md_rand", op, a, b, f, ill, lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b, f, f2;
      logic        ill;
      int          lat;
      a = $urandom;
      b = $urandom;
      model(4'd0, a, b, f, ill, lat);
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd0; in_a = a; in_b = b; in_tag = 5'd21;
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_f !== f || out_tag !== 5'd21 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold cyc%0d: valid=%b f=%h tag=%h rdy=%b want 1 %h 15 0",
                     c, out_valid, out_f, out_tag, in_ready, f);
         end
      end
      a = $urandom;
      b = $urandom;
      model(4'd3, a, b, f2, ill, lat);
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 4'd3; in_a = a; in_b = b; in_tag = 5'd9;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready: got %b want 1", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_f !== f2 || out_tag !== 5'd9) begin
         n_fail++;
         $display("FAIL b2b result: valid=%b f=%h tag=%h want 1 %h 09", out_valid, out_f, out_tag, f2);
      end
   endtask

   task automatic test_flush;
      int seen;
      // flush while a result is held
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd6; in_a = $urandom; in_b = $urandom; in_tag = 5'd3;
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done pre valid: got %b want 1", out_valid); end
      flush = 1'b1; in_valid = 1'b1; in_op = 4'd0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_done in_ready: got %b want 0", in_ready); end
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_done post: valid=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      seen = 0;
      repeat (5) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL flush_done dropped req: valid cycles %0d want 0", seen); end
      out_ready = 1'b1;
`ifdef ALU_MULDIV_EN
      // flush in the middle of a divu
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd13; in_a = $urandom; in_b = 32'($urandom_range(1, 1000));
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_div in_ready: got %b want 0", in_ready); end
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_div in_ready after: got %b want 1", in_ready); end
      seen = 0;
      repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL flush_div out_valid: cycles %0d want 0", seen); end
`endif
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd8; in_a = $urandom; in_b = $urandom; in_tag = 5'd17;
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_f !== 32'd0 || out_tag !== 5'd0 || out_illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: valid=%b rdy=%b f=%h tag=%h ill=%b want 0 1 0 0 0",
                  out_valid, in_ready, out_f, out_tag, out_illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL reset_mid lost op: valid cycles %0d want 0", seen); end
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_alu_random();
      test_muldiv_random();
      test_back_to_back();
      test_flush();
      test_directed();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
